// File: rtl/rob_ptr_ctrl_pkg.sv
// rob_ptr_ctrl_pkg: shared constants and types for the ROB pointer controller.
//   ROB_DEPTH / ROB_PTR_W : default ROB geometry (64 entries, 6-bit tags)
//   FLUSH_HOLD_DEF        : default dispatch hold after a flush
//   rob_tag_t             : ROB tag / pointer type
//   rob_ptr_state_e       : dispatch FSM states
package rob_ptr_ctrl_pkg;

  localparam int ROB_DEPTH      = 64;
  localparam int ROB_PTR_W      = 6;
  localparam int FLUSH_HOLD_DEF = 2;

  typedef logic [ROB_PTR_W-1:0] rob_tag_t;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } rob_ptr_state_e;

endpackage

// File: rtl/rob_ptr_ctrl_counter.sv
// rob_ptr_counter: modulo-DEPTH pointer register.
//   clk, i_rst_n : clock, async active-low reset (ptr -> 0)
//   clr          : synchronous clear to 0, wins over inc
//   inc          : advance by one, wrapping DEPTH-1 -> 0
//   ptr          : current pointer value
module rob_ptr_counter
  import rob_ptr_ctrl_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int W     = ROB_PTR_W
) (
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  localparam logic [W-1:0] LAST = W'(DEPTH - 1);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)  ptr <= '0;
    else if (clr)  ptr <= '0;
    else if (inc)  ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
  end

endmodule

// File: rtl/rob_ptr_ctrl.sv
// rob_ptr_ctrl: reorder-buffer pointer controller in front of the ROB RF.
//   clk, i_rst_n          : clock, async active-low reset
//   flush                 : mispredict flush (also clears the RF)
//   dispatch_req/_gnt     : allocation handshake; grant is combinational
//   wen_rf, write_addr_rf : RF new-entry write, address = tail pointer
//   rob_rf_retire_valid   : head entry retires this cycle
//   rob_fifo_head         : head pointer to the RF retire port
//   rob_full/empty/count  : registered occupancy status
//   stat_full_cycles      : cycles with a request blocked by full (saturating)
//   stat_peak_count       : peak occupancy since reset
// Build option: define ROB_OCC_STATS_EN to build the two stat counters;
// otherwise the stat outputs are tied to zero.
module rob_ptr_ctrl
  import rob_ptr_ctrl_pkg::*;
#(
  parameter int ROB_DEPTH  = rob_ptr_ctrl_pkg::ROB_DEPTH,
  parameter int PTR_W      = ROB_PTR_W,
  parameter int FLUSH_HOLD = FLUSH_HOLD_DEF   // 1..15, fits the 4-bit hold counter
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             flush,
  input  logic             dispatch_req,
  output logic             dispatch_gnt,
  output logic             wen_rf,
  output logic [PTR_W-1:0] write_addr_rf,
  input  logic             rob_rf_retire_valid,
  output logic [PTR_W-1:0] rob_fifo_head,
  output logic             rob_full,
  output logic             rob_empty,
  output logic [PTR_W:0]   rob_count,
  output logic [31:0]      stat_full_cycles,
  output logic [PTR_W:0]   stat_peak_count
);

  localparam logic [3:0]   HOLD_INIT = 4'(FLUSH_HOLD - 1);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(ROB_DEPTH);

  rob_ptr_state_e   state_q, state_d;
  logic [3:0]       hold_q, hold_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [PTR_W-1:0] head, tail;
  logic             gnt, ret_ok;

  // Full comes from the registered count only: a retire in the same cycle
  // does not free a slot for dispatch until the next cycle.
  assign rob_full  = (count_q == CNT_FULL);
  assign rob_empty = (count_q == '0);
  assign rob_count = count_q;

  // Retire on an empty ROB is ignored (and flagged below).
  assign ret_ok = rob_rf_retire_valid & ~rob_empty;

  // Dispatch FSM: a flush parks us in HOLD for FLUSH_HOLD cycles so the RF
  // clear settles before new tags go out; a flush in HOLD restarts the hold.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= RUN;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gnt     = 1'b0;
    case (state_q)
      RUN: begin
        if (flush) begin
          state_d = HOLD;
          hold_d  = HOLD_INIT;
        end
        gnt = dispatch_req & ~rob_full & ~flush;
      end
      HOLD: begin
        if (flush)             hold_d  = HOLD_INIT;
        else if (hold_q == '0) state_d = RUN;
        else                   hold_d  = hold_q - 1'b1;
      end
      default: begin
        state_d = RUN;
        hold_d  = '0;
      end
    endcase
  end

  assign dispatch_gnt  = gnt;
  assign wen_rf        = gnt;
  assign write_addr_rf = tail;
  assign rob_fifo_head = head;

  rob_ptr_counter #(.DEPTH(ROB_DEPTH), .W(PTR_W)) u_head (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .clr     (flush),
    .inc     (ret_ok),
    .ptr     (head)
  );

  rob_ptr_counter #(.DEPTH(ROB_DEPTH), .W(PTR_W)) u_tail (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .clr     (flush),
    .inc     (gnt),
    .ptr     (tail)
  );

  // Occupancy: flush wins; simultaneous grant and retire cancel out.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      case ({gnt, ret_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) count_q <= '0;
    else          count_q <= count_d;
  end

`ifdef ROB_OCC_STATS_EN
  // Stats survive flush; only reset clears them. Peak tracks the next count
  // so it moves on the same edge as rob_count.
  logic [31:0]    full_cyc_q;
  logic [PTR_W:0] peak_q;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      full_cyc_q <= '0;
      peak_q     <= '0;
    end else begin
      if (dispatch_req && rob_full && (full_cyc_q != '1))
        full_cyc_q <= full_cyc_q + 1'b1;
      if (count_d > peak_q)
        peak_q <= count_d;
    end
  end

  assign stat_full_cycles = full_cyc_q;
  assign stat_peak_count  = peak_q;
`else
  assign stat_full_cycles = '0;
  assign stat_peak_count  = '0;
`endif

`ifndef SYNTHESIS
  // Retiring from an empty ROB means the RF and this controller disagree.
  retire_on_empty: assert property (@(posedge clk) disable iff (!i_rst_n)
    !(rob_rf_retire_valid && !flush && count_q == '0));
`endif

endmodule

// File: tb/tb_rob_ptr_ctrl.sv
// Testbench for rob_ptr_ctrl: directed stimulus, an occupancy model checked
// every cycle on the falling edge, plus hand-computed literal checks.
module tb_rob_ptr_ctrl;

  localparam int DEPTH = 64;
  localparam int PW    = 6;
  localparam int FH    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fl = 1'b0, req = 1'b0, ret = 1'b0;
  logic          gnt, wen, full, empty;
  logic [PW-1:0] waddr, head;
  logic [PW:0]   cnt, peak;
  logic [31:0]   fcyc;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rob_ptr_ctrl #(.ROB_DEPTH(DEPTH), .PTR_W(PW), .FLUSH_HOLD(FH)) dut (
    .clk                 (clk),
    .i_rst_n             (rst_n),
    .flush               (fl),
    .dispatch_req        (req),
    .dispatch_gnt        (gnt),
    .wen_rf              (wen),
    .write_addr_rf       (waddr),
    .rob_rf_retire_valid (ret),
    .rob_fifo_head       (head),
    .rob_full            (full),
    .rob_empty           (empty),
    .rob_count           (cnt),
    .stat_full_cycles    (fcyc),
    .stat_peak_count     (peak)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---- model: integer head/tail/occupancy plus a "blocked cycles left" count
  int          m_head = 0, m_tail = 0, m_cnt = 0, m_blk = 0, m_peak = 0;
  longint      m_fc = 0;

  function automatic bit exp_gnt();
    return rst_n && req && !fl && (m_blk == 0) && (m_cnt < DEPTH);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_head = 0; m_tail = 0; m_cnt = 0; m_blk = 0; m_fc = 0; m_peak = 0;
    end else begin
      bit g, r;
      g = exp_gnt();
      r = ret && (m_cnt > 0);
      if (req && m_cnt == DEPTH && m_fc < 64'hFFFF_FFFF) m_fc++;
      if (fl) begin
        m_head = 0; m_tail = 0; m_cnt = 0; m_blk = FH;
      end else begin
        if (m_blk > 0) m_blk--;
        if (g) begin m_tail = (m_tail + 1) % DEPTH; m_cnt++; end
        if (r) begin m_head = (m_head + 1) % DEPTH; m_cnt--; end
      end
      if (m_cnt > m_peak) m_peak = m_cnt;
    end
  end

  always @(negedge clk) begin
    chk("gnt",   gnt,   exp_gnt());
    chk("wen",   wen,   exp_gnt());
    chk("waddr", waddr, m_tail);
    chk("head",  head,  m_head);
    chk("count", cnt,   m_cnt);
    chk("full",  full,  m_cnt == DEPTH);
    chk("empty", empty, m_cnt == 0);
`ifdef ROB_OCC_STATS_EN
    chk("stat_full", fcyc, m_fc);
    chk("stat_peak", peak, m_peak);
`else
    chk("stat_full", fcyc, 0);
    chk("stat_peak", peak, 0);
`endif
  end

  // Apply inputs just after a rising edge, return at the following falling edge.
  task automatic drive(input logic r, input logic rt, input logic f);
    @(posedge clk); #1;
    req = r; ret = rt; fl = f;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_count", cnt, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full",  full, 0);
    chk("rst_gnt",   gnt, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // three allocations: tags 0,1,2
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0);
      chk("alloc_wen", wen, 1);
      chk("alloc_tag", waddr, i);
    end
    drive(0, 0, 0);
    chk("alloc_cnt3", cnt, 3);
    chk("alloc_nempty", empty, 0);

    // fill to 64 then keep requesting for 5 cycles
    repeat (61) drive(1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0);
      chk("full_gnt", gnt, 0);
      chk("full_flag", full, 1);
    end
    drive(0, 1, 0);
`ifdef ROB_OCC_STATS_EN
    chk("stat_fc5", fcyc, 5);
    chk("stat_pk64", peak, 64);
`endif
    drive(1, 0, 0);
    chk("ret_head1", head, 1);
    chk("ret_cnt63", cnt, 63);
    chk("resume_gnt", gnt, 1);
    chk("resume_tag0", waddr, 0);
    drive(0, 0, 0);
    chk("refill_cnt", cnt, 64);

    // head to 63, tail to 5 (count 6), then retire across the wrap
    repeat (62) drive(0, 1, 0);
    repeat (4)  drive(1, 0, 0);
    drive(0, 1, 0);
    chk("pre_wrap_head", head, 63);
    chk("pre_wrap_cnt", cnt, 6);
    drive(0, 0, 0);
    chk("wrap_head0", head, 0);
    chk("wrap_cnt5", cnt, 5);

    // count 10, simultaneous grant + retire
    repeat (5) drive(1, 0, 0);
    drive(1, 1, 0);
    chk("both_cnt10", cnt, 10);
    chk("both_tag10", waddr, 10);
    drive(0, 0, 0);
    chk("both_cnt", cnt, 10);
    chk("both_head1", head, 1);
    chk("both_tail11", waddr, 11);

    // count 20, flush with a pending request
    repeat (10) drive(1, 0, 0);
    drive(1, 0, 1);
    chk("flush_cnt20", cnt, 20);
    chk("flush_gnt", gnt, 0);
    drive(1, 0, 0);
    chk("flush_cnt0", cnt, 0);
    chk("flush_head0", head, 0);
    chk("hold1_gnt", gnt, 0);
    drive(1, 0, 0);
    chk("hold2_gnt", gnt, 0);
    drive(1, 0, 0);
    chk("post_hold_gnt", gnt, 1);
    chk("post_hold_tag", waddr, 0);
`ifdef ROB_OCC_STATS_EN
    chk("stat_fc_kept", fcyc, 5);
    chk("stat_pk_kept", peak, 64);
`endif

    // flush while already holding restarts the hold
    drive(0, 0, 1);
    drive(1, 0, 0);
    drive(1, 0, 1);
    drive(1, 0, 0);
    chk("reflush_gnt1", gnt, 0);
    drive(1, 0, 0);
    chk("reflush_gnt2", gnt, 0);
    drive(1, 0, 0);
    chk("reflush_gnt3", gnt, 1);
    repeat (3) drive(1, 1, 0);

    // asynchronous reset mid-operation
    @(posedge clk); #1;
    req = 0; ret = 0; fl = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_cnt", cnt, 0);
    chk("mid_rst_empty", empty, 1);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    drive(1, 0, 0);
    chk("after_rst_tag", waddr, 0);
    chk("after_rst_gnt", gnt, 1);
    drive(0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
